antitheft_timer: RTL

- Timing stage paired with the anti-theft control FSM.
- Consumes the FSM's `start_timer` and `interval[1:0]`; produces `expired` and `one_hz_enable` back to it.
- Holds four reprogrammable delay parameters (seconds), a 1 Hz tick generator, and a seconds down-counter.
- Sits between the board clock/switch inputs and the FSM; no other block drives FSM timing.

---
 rtl/antitheft_pkg.sv | 27 ++
 rtl/antitheft_timer_if.sv | 26 ++
 rtl/antitheft_timer_divider.sv | 39 +++
 rtl/antitheft_timer.sv | 109 ++++++++++
 4 files changed

// File: rtl/antitheft_pkg.sv
// Shared definitions for the anti-theft FSM and its timing stage:
// interval encodings, default delays and the seconds width.
package antitheft_pkg;

  localparam int SEC_W = 4;

  typedef logic [SEC_W-1:0] seconds_t;

  localparam logic [1:0] INT_ARM = 2'b00;
  localparam logic [1:0] INT_DRV = 2'b01;
  localparam logic [1:0] INT_PAS = 2'b10;
  localparam logic [1:0] INT_ALM = 2'b11;

  localparam int DEF_ARM_S = 6;
  localparam int DEF_DRV_S = 8;
  localparam int DEF_PAS_S = 15;
  localparam int DEF_ALM_S = 10;

  // ZERO_LOAD delays the expiry of a zero-length interval by one cycle.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNTING,
    ST_ZERO_LOAD,
    ST_EXPIRE
  } timer_state_e;

endpackage

// File: rtl/antitheft_timer_if.sv
// Signal bundle between the anti-theft control FSM (master) and the
// timing stage (slave).
interface antitheft_timer_if;
  import antitheft_pkg::*;

  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  seconds_t   time_value;
  logic       one_hz_enable;
  logic       expired;
  logic       busy;
  seconds_t   seconds_left;

  modport master (
    output start_timer, interval, reprogram, time_param_sel, time_value,
    input  one_hz_enable, expired, busy, seconds_left
  );

  modport slave (
    input  start_timer, interval, reprogram, time_param_sel, time_value,
    output one_hz_enable, expired, busy, seconds_left
  );

endinterface

// File: rtl/antitheft_timer_divider.sv
// Free-running 0..CLK_HZ-1 divider with a synchronous clear; tick is
// registered and high exactly while the divider sits at CLK_HZ-1.
module one_hz_divider #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // tick is derived from the next divider value so it lines up with div_q.
  always_comb begin
    div_d = div_q + CNT_W'(1);
    if (clear || (div_q == LAST)) begin
      div_d = '0;
    end
    tick_d = (div_d == LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/antitheft_timer.sv
// Timing stage for the anti-theft FSM: reprogrammable delay store,
// 1 Hz tick and a seconds down-counter with a one-cycle expiry pulse.
module antitheft_timer
  import antitheft_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int T_ARM_DEF = DEF_ARM_S,
  parameter int T_DRV_DEF = DEF_DRV_S,
  parameter int T_PAS_DEF = DEF_PAS_S,
  parameter int T_ALM_DEF = DEF_ALM_S
) (
  input  logic              clock,
  input  logic              reset,
  antitheft_timer_if.slave  bus
);

  timer_state_e state_q, state_d;
  seconds_t     count_q, count_d;
  seconds_t     param_q [4];
  seconds_t     param_d [4];
  logic         start_prev_q;
  logic [1:0]   interval_prev_q;
  logic         tick;
  logic         load;
  logic         div_clear;
  seconds_t     load_value;

  // A retarget (interval change while start_timer stays high) is a restart.
  always_comb begin
    load       = bus.start_timer &&
                 (!start_prev_q || (bus.interval != interval_prev_q));
    load_value = param_q[bus.interval];
    div_clear  = load && !bus.reprogram;
  end

  one_hz_divider #(
    .CLK_HZ (CLK_HZ)
  ) u_divider (
    .clock (clock),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  always_comb begin
    param_d = param_q;
    if (bus.reprogram) begin
      param_d[bus.time_param_sel] = bus.time_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      count_q          <= '0;
      start_prev_q     <= 1'b0;
      interval_prev_q  <= INT_ARM;
      param_q[INT_ARM] <= seconds_t'(T_ARM_DEF);
      param_q[INT_DRV] <= seconds_t'(T_DRV_DEF);
      param_q[INT_PAS] <= seconds_t'(T_PAS_DEF);
      param_q[INT_ALM] <= seconds_t'(T_ALM_DEF);
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      start_prev_q    <= bus.start_timer;
      interval_prev_q <= bus.interval;
      param_q         <= param_d;
    end
  end

  // A write always aborts; otherwise a load overrides whatever was running,
  // including a tick landing on the same edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.reprogram) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
      state_d = (load_value == '0) ? ST_ZERO_LOAD : ST_COUNTING;
    end else begin
      case (state_q)
        ST_COUNTING: begin
          if (!bus.start_timer) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else if (tick) begin
            count_d = count_q - seconds_t'(1);
            if (count_q == seconds_t'(1)) begin
              state_d = ST_EXPIRE;
            end
          end
        end
        ST_ZERO_LOAD: state_d = ST_EXPIRE;
        ST_EXPIRE:    state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy          = (state_q == ST_COUNTING);
    bus.expired       = (state_q == ST_EXPIRE);
    bus.seconds_left  = count_q;
    bus.one_hz_enable = tick;
  end

endmodule
